// File: rtl/inbus_read_ctrl.sv
// Input-bus read master: issues a one-cycle read strobe, waits the device latency,
// then returns the OR-merged peripheral byte to the core with a collision flag.
module inbus_read_ctrl #(
   parameter int unsigned NDEV       = 4,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_req,
   input  logic [7:0]          rd_addr,
   output logic                rd_ready,
   output logic                rd_valid,
   output logic [7:0]          rd_data,
   output logic                rd_err,
   output logic [7:0]          INBUS_ADDR,
   output logic                INBUS_RE,
   input  logic [8*NDEV-1:0]   INBUS_DATA_ALL
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                re_d;
   logic [DATA_W-1:0]   addr_d;
   logic                valid_d;
   logic [DATA_W-1:0]   data_d;
   logic                err_d;
   logic [DATA_W-1:0]   merged;
   logic                nz_seen;
   logic                multi_nz;

   // OR-merge of all device buses plus a population check for >=2 non-zero buses
   always_comb begin
      merged   = '0;
      nz_seen  = 1'b0;
      multi_nz = 1'b0;
      for (int unsigned k = 0; k < NDEV; k++) begin
         merged = merged | INBUS_DATA_ALL[DATA_W*k +: DATA_W];
         if (INBUS_DATA_ALL[DATA_W*k +: DATA_W] != '0) begin
            if (nz_seen) multi_nz = 1'b1;
            nz_seen = 1'b1;
         end
      end
   end

   assign rd_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Next-state and next-value logic for every registered output
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      re_d    = 1'b0;
      addr_d  = '0;
      valid_d = 1'b0;
      data_d  = rd_data;
      err_d   = rd_err;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               state_d = ST_STROBE;
               re_d    = 1'b1;
               addr_d  = rd_addr;
            end
         end
         ST_STROBE: begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               data_d  = merged;
               err_d   = multi_nz;
               valid_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (rd_req) begin
               state_d = ST_STROBE;
               re_d    = 1'b1;
               addr_d  = rd_addr;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset abandons any in-flight read and clears every output
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         INBUS_RE   <= 1'b0;
         INBUS_ADDR <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         rd_err     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         INBUS_RE   <= re_d;
         INBUS_ADDR <= addr_d;
         rd_valid   <= valid_d;
         rd_data    <= data_d;
         rd_err     <= err_d;
      end
   end

endmodule
